// File: rtl/tf_issue_ctrl.sv
// Twiddle-factor issue controller: gathers 16 TF words from the TF memory
// into lane registers and presents each group with the modulus via valid/ready.
//
// Ports:
//   clk, rst (async active-low)
//   start, base_addr, num_groups, modulus   request (latched on start in IDLE)
//   busy, done                              status
//   tf_rd_en, tf_rd_addr, tf_rd_data        synchronous TF memory read port
//   TF0_out..TF15_out, modulus_out          presented group
//   tf_valid, tf_ready                      group handshake
`ifndef D_width
`define D_width 32
`endif

module tf_issue_ctrl #(
    parameter int ADDR_W = 10,
    parameter int GRP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [GRP_W-1:0]  num_groups,
    input  logic [`D_width-1:0] modulus,
    output logic              busy,
    output logic              done,
    output logic              tf_rd_en,
    output logic [ADDR_W-1:0] tf_rd_addr,
    input  logic [`D_width-1:0] tf_rd_data,
    output logic [`D_width-1:0] TF0_out,
    output logic [`D_width-1:0] TF1_out,
    output logic [`D_width-1:0] TF2_out,
    output logic [`D_width-1:0] TF3_out,
    output logic [`D_width-1:0] TF4_out,
    output logic [`D_width-1:0] TF5_out,
    output logic [`D_width-1:0] TF6_out,
    output logic [`D_width-1:0] TF7_out,
    output logic [`D_width-1:0] TF8_out,
    output logic [`D_width-1:0] TF9_out,
    output logic [`D_width-1:0] TF10_out,
    output logic [`D_width-1:0] TF11_out,
    output logic [`D_width-1:0] TF12_out,
    output logic [`D_width-1:0] TF13_out,
    output logic [`D_width-1:0] TF14_out,
    output logic [`D_width-1:0] TF15_out,
    output logic [`D_width-1:0] modulus_out,
    output logic              tf_valid,
    input  logic              tf_ready
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        PRESENT,
        DONE
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0]   base_q;
    logic [GRP_W-1:0]    ngrp_q;
    logic [`D_width-1:0] mod_q;
    logic [GRP_W-1:0]    g_q;
    logic [3:0]          k_q;
    logic                cap_en;
    logic [3:0]          cap_k;
    logic [`D_width-1:0] lane_q [16];

    logic [ADDR_W-1:0] fetch_addr;
    logic [GRP_W:0]    g_inc;
    logic              xfer;

    // 16*g + k, reduced to ADDR_W bits (silent wrap).
    assign fetch_addr = base_q + ADDR_W'({g_q, 4'b0000}) + ADDR_W'(k_q);
    assign g_inc      = {1'b0, g_q} + (GRP_W+1)'(1);
    assign xfer       = (state == PRESENT) && tf_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            base_q <= '0;
            ngrp_q <= '0;
            mod_q  <= '0;
            g_q    <= '0;
            k_q    <= '0;
            cap_en <= 1'b0;
            cap_k  <= '0;
        end else begin
            state  <= state_n;
            // Read data arrives one cycle later; remember which lane it is.
            cap_en <= (state == FETCH);
            cap_k  <= k_q;
            if (state == IDLE && start) begin
                base_q <= base_addr;
                ngrp_q <= num_groups;
                mod_q  <= modulus;
                g_q    <= '0;
                k_q    <= '0;
            end else if (state == FETCH) begin
                k_q <= k_q + 4'd1;
            end else if (xfer) begin
                g_q <= g_q + GRP_W'(1);
                k_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) lane_q[i] <= '0;
        end else if (cap_en) begin
            lane_q[cap_k] <= tf_rd_data;
        end
    end

    always_comb begin
        state_n    = state;
        busy       = 1'b1;
        done       = 1'b0;
        tf_rd_en   = 1'b0;
        tf_rd_addr = '0;
        tf_valid   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_n = (num_groups == '0) ? DONE : FETCH;
            end
            FETCH: begin
                tf_rd_en   = 1'b1;
                tf_rd_addr = fetch_addr;
                if (k_q == 4'd15) state_n = DRAIN;
            end
            DRAIN: state_n = PRESENT;
            PRESENT: begin
                tf_valid = 1'b1;
                if (tf_ready)
                    state_n = (g_inc < {1'b0, ngrp_q}) ? FETCH : DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign modulus_out = mod_q;
    assign TF0_out  = lane_q[0];
    assign TF1_out  = lane_q[1];
    assign TF2_out  = lane_q[2];
    assign TF3_out  = lane_q[3];
    assign TF4_out  = lane_q[4];
    assign TF5_out  = lane_q[5];
    assign TF6_out  = lane_q[6];
    assign TF7_out  = lane_q[7];
    assign TF8_out  = lane_q[8];
    assign TF9_out  = lane_q[9];
    assign TF10_out = lane_q[10];
    assign TF11_out = lane_q[11];
    assign TF12_out = lane_q[12];
    assign TF13_out = lane_q[13];
    assign TF14_out = lane_q[14];
    assign TF15_out = lane_q[15];

endmodule

// File: tb/tb_tf_issue_ctrl.sv
// Testbench for tf_issue_ctrl: directed and random jobs against a
// reference model of the address sequence and expected lane contents.
`ifndef D_width
`define D_width 32
`endif

module tb_tf_issue_ctrl;

    localparam int AW = 10;
    localparam int GW = 8;
    localparam int DW = `D_width;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [GW-1:0] num_groups = '0;
    logic [DW-1:0] modulus = '0;
    logic          busy, done, tf_rd_en, tf_valid;
    logic          tf_ready = 1'b0;
    logic [AW-1:0] tf_rd_addr;
    logic [DW-1:0] tf_rd_data = '0;
    logic [DW-1:0] modulus_out;
    logic [DW-1:0] tf_out [16];

    logic [DW-1:0] rom [1024];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (tf_rd_en) tf_rd_data <= rom[tf_rd_addr];

    tf_issue_ctrl #(.ADDR_W(AW), .GRP_W(GW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .base_addr(base_addr), .num_groups(num_groups),
        .modulus(modulus), .busy(busy), .done(done),
        .tf_rd_en(tf_rd_en), .tf_rd_addr(tf_rd_addr),
        .tf_rd_data(tf_rd_data),
        .TF0_out(tf_out[0]),   .TF1_out(tf_out[1]),
        .TF2_out(tf_out[2]),   .TF3_out(tf_out[3]),
        .TF4_out(tf_out[4]),   .TF5_out(tf_out[5]),
        .TF6_out(tf_out[6]),   .TF7_out(tf_out[7]),
        .TF8_out(tf_out[8]),   .TF9_out(tf_out[9]),
        .TF10_out(tf_out[10]), .TF11_out(tf_out[11]),
        .TF12_out(tf_out[12]), .TF13_out(tf_out[13]),
        .TF14_out(tf_out[14]), .TF15_out(tf_out[15]),
        .modulus_out(modulus_out),
        .tf_valid(tf_valid), .tf_ready(tf_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rden"}, tf_rd_en, 0);
        chk({tag, "_addr"}, tf_rd_addr, 0);
        chk({tag, "_valid"}, tf_valid, 0);
        chk({tag, "_mod"}, modulus_out, 0);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_lane%0d", tag, i), tf_out[i], 0);
    endtask

    function automatic int tf_addr(int base, int g, int k);
        return (base + 16 * g + k) % 1024;
    endfunction

    task automatic check_lanes(input string tag, input int base,
                               input int g, input logic [DW-1:0] m);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_g%0d_lane%0d", tag, g, i),
                tf_out[i], rom[tf_addr(base, g, i)]);
        chk({tag, "_modout"}, modulus_out, m);
    endtask

    // One complete job; stalls tf_ready up to stall_max cycles per group,
    // optionally re-pulses start with another base during FETCH.
    task automatic run_job(input string tag, input int base, input int ng,
                           input logic [DW-1:0] m, input int stall_max,
                           input bit restart);
        @(negedge clk);
        start      = 1'b1;
        base_addr  = AW'(base);
        num_groups = GW'(ng);
        modulus    = m;
        @(posedge clk);
        #1;
        start      = 1'b0;
        base_addr  = AW'($urandom);
        num_groups = GW'($urandom);
        modulus    = DW'($urandom);
        if (ng == 0) begin
            @(negedge clk);
            chk({tag, "_z_done"}, done, 1);
            chk({tag, "_z_busy"}, busy, 1);
            chk({tag, "_z_rden"}, tf_rd_en, 0);
            chk({tag, "_z_valid"}, tf_valid, 0);
            @(negedge clk);
            chk({tag, "_z_done2"}, done, 0);
            chk({tag, "_z_busy2"}, busy, 0);
            chk({tag, "_z_rden2"}, tf_rd_en, 0);
            return;
        end
        for (int g = 0; g < ng; g++) begin
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                chk($sformatf("%s_rden_g%0d_k%0d", tag, g, k), tf_rd_en, 1);
                chk($sformatf("%s_addr_g%0d_k%0d", tag, g, k),
                    tf_rd_addr, tf_addr(base, g, k));
                chk({tag, "_fetch_valid"}, tf_valid, 0);
                chk({tag, "_fetch_busy"}, busy, 1);
                tf_ready = 1'($urandom);
                if (restart && g == 0 && k == 4) begin
                    start     = 1'b1;
                    base_addr = AW'(base + 37);
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
            start = 1'b0;
            chk({tag, "_drain_rden"}, tf_rd_en, 0);
            chk({tag, "_drain_valid"}, tf_valid, 0);
            chk({tag, "_drain_done"}, done, 0);
            begin
                int stall;
                stall = $urandom_range(0, stall_max);
                for (int s = 0; s <= stall; s++) begin
                    @(negedge clk);
                    chk({tag, "_pres_valid"}, tf_valid, 1);
                    chk({tag, "_pres_rden"}, tf_rd_en, 0);
                    check_lanes({tag, "_pres"}, base, g, m);
                    tf_ready = (s == stall);
                end
            end
        end
        @(negedge clk);
        tf_ready = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_done_busy"}, busy, 1);
        chk({tag, "_done_valid"}, tf_valid, 0);
        @(negedge clk);
        chk({tag, "_after_done"}, done, 0);
        chk({tag, "_after_busy"}, busy, 0);
        check_lanes({tag, "_hold"}, base, ng - 1, m);
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) rom[a] = DW'(a + 100);
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        run_job("basic", 'h010, 1, DW'('h3001), 0, 1'b0);
        chk("basic_lane0", tf_out[0], 116);
        chk("basic_lane15", tf_out[15], 131);

        run_job("stall2", 'h010, 2, DW'('h1234), 5, 1'b0);

        run_job("wrap", 'h3F8, 1, DW'(7681), 0, 1'b0);
        chk("wrap_lane8", tf_out[8], rom[0]);

        run_job("zero", 'h055, 0, DW'(12289), 0, 1'b0);
        chk("zero_modout", modulus_out, 12289);

        run_job("restart", 'h100, 1, DW'(3329), 2, 1'b0);
        run_job("ignstart", 'h120, 1, DW'(3329), 2, 1'b1);

        // Reset while reading lane 7 of the first group.
        @(negedge clk);
        start      = 1'b1;
        base_addr  = AW'('h200);
        num_groups = GW'(3);
        modulus    = DW'(17);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        chk("rstmid_addr_k7", tf_rd_addr, 'h207);
        rst = 1'b0;
        #1;
        chk_zero_outputs("rstmid");
        @(negedge clk);
        rst = 1'b1;
        run_job("post_rst", 'h200, 1, DW'(17), 1, 1'b0);

        for (int a = 0; a < 1024; a++) rom[a] = DW'($urandom);
        for (int j = 0; j < 6; j++)
            run_job($sformatf("rnd%0d", j), int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 3)), DW'($urandom), 4,
                    1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
